// File: rtl/controle_varredura_servo_pkg.sv
// Shared definitions for the servo sweep sequencer: state codes, default timing
// and position limits, and the counter terminal-value helper.
package controle_varredura_servo_pkg;

    localparam logic [2:0] INICIAL   = 3'd0;
    localparam logic [2:0] POSICIONA = 3'd1;
    localparam logic [2:0] ASSENTA   = 3'd2;
    localparam logic [2:0] MEDE      = 3'd3;
    localparam logic [2:0] AGUARDA   = 3'd4;
    localparam logic [2:0] PROXIMA   = 3'd5;

    typedef enum logic [2:0] {
        E_INICIAL   = INICIAL,
        E_POSICIONA = POSICIONA,
        E_ASSENTA   = ASSENTA,
        E_MEDE      = MEDE,
        E_AGUARDA   = AGUARDA,
        E_PROXIMA   = PROXIMA
    } estado_e;

    // 0.5 s settle and 1 s measurement timeout at 50 MHz
    localparam int unsigned TEMPO_ASSENTAMENTO_PADRAO = 25_000_000;
    localparam int unsigned TEMPO_TIMEOUT_PADRAO      = 50_000_000;
    localparam logic [2:0]  POS_MIN_PADRAO            = 3'd0;
    localparam logic [2:0]  POS_MAX_PADRAO            = 3'd7;

    function automatic logic [31:0] ultimo_ciclo(input int unsigned n);
        return 32'(n - 1);
    endfunction

endpackage

// File: rtl/controle_varredura_servo_contador_timer.sv
// 32-bit cycle counter with synchronous clear and enable; fim_o flags the
// last cycle of a MAX-cycle interval (count == MAX-1).
module contador_timer
    import controle_varredura_servo_pkg::*;
#(
    parameter int unsigned MAX = 1
)(
    input  logic clock,
    input  logic reset,
    input  logic limpa_i,
    input  logic habilita_i,
    output logic fim_o
);

    localparam logic [31:0] ULTIMO = ultimo_ciclo(MAX);

    logic [31:0] cont_q, cont_d;

    always_comb begin
        cont_d = cont_q;
        if (limpa_i)
            cont_d = '0;
        else if (habilita_i)
            cont_d = cont_q + 32'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cont_q <= '0;
        else
            cont_q <= cont_d;
    end

    assign fim_o = (cont_q == ULTIMO);

endmodule

// File: rtl/controle_varredura_servo.sv
// Ping-pong sweep sequencer: positions the servo, waits to settle, requests a
// range measurement and waits for its completion or a timeout before moving on.
module controle_varredura_servo
    import controle_varredura_servo_pkg::*;
#(
    parameter int unsigned TEMPO_ASSENTAMENTO = TEMPO_ASSENTAMENTO_PADRAO,
    parameter int unsigned TEMPO_TIMEOUT      = TEMPO_TIMEOUT_PADRAO,
    parameter logic [2:0]  POS_MIN            = POS_MIN_PADRAO,
    parameter logic [2:0]  POS_MAX            = POS_MAX_PADRAO
)(
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       medida_pronta,
    output logic [2:0] largura,
    output logic       medir,
    output logic [2:0] posicao_medida,
    output logic       timeout,
    output logic       fim_ciclo,
    output logic [2:0] db_estado
);

    estado_e    estado_q, estado_d;
    logic [2:0] largura_q, largura_d;
    logic [2:0] posicao_q, posicao_d;
    logic       sobe_q, sobe_d;
    logic       medir_q, medir_d;
    logic       timeout_q, timeout_d;
    logic       fim_ciclo_q, fim_ciclo_d;
    logic       fim_assenta, fim_espera;

    contador_timer #(.MAX(TEMPO_ASSENTAMENTO)) u_assenta (
        .clock      (clock),
        .reset      (reset),
        .limpa_i    (estado_q == E_INICIAL || estado_q == E_POSICIONA),
        .habilita_i (estado_q == E_ASSENTA),
        .fim_o      (fim_assenta)
    );

    contador_timer #(.MAX(TEMPO_TIMEOUT)) u_espera (
        .clock      (clock),
        .reset      (reset),
        .limpa_i    (estado_q == E_INICIAL || estado_q == E_MEDE),
        .habilita_i (estado_q == E_AGUARDA && !medida_pronta),
        .fim_o      (fim_espera)
    );

    always_comb begin
        estado_d    = estado_q;
        largura_d   = largura_q;
        posicao_d   = posicao_q;
        sobe_d      = sobe_q;
        medir_d     = 1'b0;
        timeout_d   = 1'b0;
        fim_ciclo_d = 1'b0;

        // stopping overrides everything and leaves the servo where it is
        if (estado_q != E_INICIAL && !ligar) begin
            estado_d = E_INICIAL;
        end else begin
            case (estado_q)
                E_INICIAL: begin
                    if (ligar) begin
                        largura_d = POS_MIN;
                        sobe_d    = 1'b1;
                        estado_d  = E_POSICIONA;
                    end
                end
                E_POSICIONA: estado_d = E_ASSENTA;
                E_ASSENTA: begin
                    if (fim_assenta)
                        estado_d = E_MEDE;
                end
                E_MEDE: begin
                    medir_d  = 1'b1;
                    estado_d = E_AGUARDA;
                end
                E_AGUARDA: begin
                    // a done pulse on the expiry cycle still counts as a measurement
                    if (medida_pronta) begin
                        posicao_d = largura_q;
                        estado_d  = E_PROXIMA;
                    end else if (fim_espera) begin
                        timeout_d = 1'b1;
                        posicao_d = largura_q;
                        estado_d  = E_PROXIMA;
                    end
                end
                E_PROXIMA: begin
                    estado_d = E_POSICIONA;
                    if (sobe_q) begin
                        if (largura_q < POS_MAX) begin
                            largura_d = largura_q + 3'd1;
                        end else begin
                            sobe_d      = 1'b0;
                            largura_d   = largura_q - 3'd1;
                            fim_ciclo_d = 1'b1;
                        end
                    end else begin
                        if (largura_q > POS_MIN) begin
                            largura_d = largura_q - 3'd1;
                        end else begin
                            sobe_d      = 1'b1;
                            largura_d   = largura_q + 3'd1;
                            fim_ciclo_d = 1'b1;
                        end
                    end
                end
                default: estado_d = E_INICIAL;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q    <= E_INICIAL;
            largura_q   <= POS_MIN;
            posicao_q   <= POS_MIN;
            sobe_q      <= 1'b1;
            medir_q     <= 1'b0;
            timeout_q   <= 1'b0;
            fim_ciclo_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            largura_q   <= largura_d;
            posicao_q   <= posicao_d;
            sobe_q      <= sobe_d;
            medir_q     <= medir_d;
            timeout_q   <= timeout_d;
            fim_ciclo_q <= fim_ciclo_d;
        end
    end

    assign largura        = largura_q;
    assign posicao_medida = posicao_q;
    assign medir          = medir_q;
    assign timeout        = timeout_q;
    assign fim_ciclo      = fim_ciclo_q;
    assign db_estado      = estado_q;

endmodule

// File: tb/tb_controle_varredura_servo.sv
// Randomized bench for the sweep sequencer against a timeline model: each
// position is a window of cycles whose phase follows from its offset.
module tb_controle_varredura_servo;
    import controle_varredura_servo_pkg::*;

    localparam int T    = 4;
    localparam int TT   = 10;
    localparam int PMIN = 0;
    localparam int PMAX = 7;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ligar = 1'b0;
    logic       medida_pronta = 1'b0;
    logic [2:0] largura, posicao_medida, db_estado;
    logic       medir, timeout, fim_ciclo;

    int n_cmp = 0;
    int n_err = 0;
    int queda = 0;

    always #5 clock = ~clock;

    controle_varredura_servo #(
        .TEMPO_ASSENTAMENTO (T),
        .TEMPO_TIMEOUT      (TT),
        .POS_MIN            (3'(PMIN)),
        .POS_MAX            (3'(PMAX))
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ligar          (ligar),
        .medida_pronta  (medida_pronta),
        .largura        (largura),
        .medir          (medir),
        .posicao_medida (posicao_medida),
        .timeout        (timeout),
        .fim_ciclo      (fim_ciclo),
        .db_estado      (db_estado)
    );

    // model: run flag, index into the ping-pong sequence, cycle offset t
    // within the current position window (0 positioning, 1..T settling,
    // T+1 request, T+2.. waiting) and a flag for the advance cycle
    bit run, prox;
    int idx, t;
    int e_larg, e_pos;
    bit e_medir, e_tmo, e_fim;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pos_de(input int k);
        int span = PMAX - PMIN;
        int r = k % (2 * span);
        return (r <= span) ? PMIN + r : PMAX - (r - span);
    endfunction

    function automatic logic [2:0] est_esp();
        if (!run)       return INICIAL;
        if (prox)       return PROXIMA;
        if (t == 0)     return POSICIONA;
        if (t <= T)     return ASSENTA;
        if (t == T + 1) return MEDE;
        return AGUARDA;
    endfunction

    task automatic modelo_reset();
        run = 0; prox = 0; idx = 0; t = 0;
        e_larg = PMIN; e_pos = PMIN;
        e_medir = 0; e_tmo = 0; e_fim = 0;
    endtask

    task automatic modelo_passo(input bit l, input bit p);
        int r;
        e_medir = 0; e_tmo = 0; e_fim = 0;
        if (!run) begin
            if (l) begin
                run = 1; prox = 0; idx = 0; t = 0; e_larg = PMIN;
            end
        end else if (!l) begin
            run = 0;
        end else if (prox) begin
            r = idx % (2 * (PMAX - PMIN));
            e_fim = (r == PMAX - PMIN) || (r == 0 && idx > 0);
            idx++;
            e_larg = pos_de(idx);
            prox = 0; t = 0;
        end else if (t <= T) begin
            t++;
        end else if (t == T + 1) begin
            e_medir = 1; t++;
        end else if (p) begin
            prox = 1; e_pos = pos_de(idx);
        end else if (t - (T + 2) == TT - 1) begin
            prox = 1; e_tmo = 1; e_pos = pos_de(idx);
        end else begin
            t++;
        end
    endtask

    task automatic verifica(input string pfx);
        chk({pfx, "_db_estado"}, 32'(db_estado), 32'(est_esp()));
        chk({pfx, "_largura"},   32'(largura), 32'(e_larg));
        chk({pfx, "_posicao"},   32'(posicao_medida), 32'(e_pos));
        chk({pfx, "_medir"},     32'(medir), 32'(e_medir));
        chk({pfx, "_timeout"},   32'(timeout), 32'(e_tmo));
        chk({pfx, "_fim_ciclo"}, 32'(fim_ciclo), 32'(e_fim));
    endtask

    task automatic ciclo(input int pr);
        @(negedge clock);
        if (queda > 0) begin
            ligar = 1'b0;
            queda--;
        end else begin
            ligar = 1'b1;
            if ($urandom_range(0, 399) == 0) queda = $urandom_range(1, 6);
        end
        medida_pronta = (pr > 0) ? ($urandom_range(0, pr - 1) == 0) : 1'b0;
        @(posedge clock);
        modelo_passo(ligar, medida_pronta);
        #1;
        verifica("run");
    endtask

    task automatic reset_assincrono();
        bit achou = 0;
        for (int i = 0; i < 300 && !achou; i++) begin
            if (run && !prox && t >= T + 2) achou = 1;
            else ciclo(0);
        end
        chk("espera_aguarda", 32'(achou), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_assinc_estado",  32'(db_estado), 32'(INICIAL));
        chk("rst_assinc_largura", 32'(largura), 32'(PMIN));
        chk("rst_assinc_posicao", 32'(posicao_medida), 32'(PMIN));
        chk("rst_assinc_medir",   32'(medir), 32'd0);
        chk("rst_assinc_timeout", 32'(timeout), 32'd0);
        chk("rst_assinc_fim",     32'(fim_ciclo), 32'd0);
        modelo_reset();
        @(negedge clock);
        reset = 1'b0;
        ligar = 1'b0;
        medida_pronta = 1'b1;
        @(posedge clock);
        modelo_passo(ligar, medida_pronta);
        #1;
        verifica("pos_reset");
    endtask

    initial begin
        int prob [4] = '{8, 2, 0, 12};
        modelo_reset();
        repeat (3) @(posedge clock);
        #1;
        verifica("reset");
        @(negedge clock);
        reset = 1'b0;
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 1500; c++) ciclo(prob[seg]);
            reset_assincrono();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
